// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Computes one bit per cycle and stalls the front end until the result is ready.
module ex_muldiv #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_valid,
   input  logic [2:0]            funct3,
   input  logic [XLEN-1:0]       reg1_i,
   input  logic [XLEN-1:0]       reg2_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic                  rd_enable_i,
   input  logic                  flush_i,
   output logic                  stall_req_o,
   output logic                  result_valid_o,
   output logic [XLEN-1:0]       result_o,
   output logic [REG_ADDR_W-1:0] rd_o,
   output logic                  rd_enable_o
);

   localparam int unsigned CntW = $clog2(XLEN);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [2:0]              f3_q, f3_d;
   logic                    sign_q, sign_d;
   logic [XLEN-1:0]         addend_q, addend_d;
   // Multiply: product {hi, lo}. Divide: {remainder, quotient}.
   logic [2*XLEN-1:0]       acc_q, acc_d;
   logic [XLEN-1:0]         result_q, result_d;
   logic [REG_ADDR_W-1:0]   rd_q, rd_d;
   logic                    rd_en_q, rd_en_d;
   logic                    valid_q, valid_d;

   logic                    signed1, signed2, s1, s2;
   logic [XLEN-1:0]         abs1, abs2;
   logic                    in_div, div_zero, div_ovf;
   logic [XLEN:0]           mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0]       mul_next, div_next, step_next, mul_full;
   logic [XLEN-1:0]         div_val, final_res;

   always_comb begin
      signed1  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      signed2  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      s1       = signed1 & reg1_i[XLEN-1];
      s2       = signed2 & reg2_i[XLEN-1];
      abs1     = s1 ? -reg1_i : reg1_i;
      abs2     = s2 ? -reg2_i : reg2_i;
      in_div   = funct3[2];
      div_zero = in_div && (reg2_i == '0);
      div_ovf  = in_div && !funct3[0] && (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (reg2_i == '1);
   end

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend_q & {XLEN{acc_q[0]}}};
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, addend_q};
      div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      step_next = f3_q[2] ? div_next : mul_next;
      // High-half results need the full-width negation, not just the upper word.
      mul_full  = sign_q ? -step_next : step_next;
      div_val   = f3_q[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
      if (f3_q[2]) begin
         final_res = sign_q ? -div_val : div_val;
      end else if (f3_q[1:0] == 2'b00) begin
         final_res = mul_full[XLEN-1:0];
      end else begin
         final_res = mul_full[2*XLEN-1:XLEN];
      end
   end

   assign stall_req_o = (state_q == StBusy) || ((state_q == StIdle) && op_valid && !flush_i);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      sign_d   = sign_q;
      addend_d = addend_q;
      acc_d    = acc_q;
      result_d = result_q;
      rd_d     = rd_q;
      rd_en_d  = rd_en_q;
      valid_d  = 1'b0;
      if (flush_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (op_valid) begin
                  f3_d    = funct3;
                  rd_d    = rd_i;
                  rd_en_d = rd_enable_i;
                  sign_d  = (funct3 == 3'b110) ? s1 : (s1 ^ s2);
                  cnt_d   = '0;
                  if (div_zero) begin
                     result_d = funct3[1] ? reg1_i : '1;
                     valid_d  = 1'b1;
                     state_d  = StDone;
                  end else if (div_ovf) begin
                     result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                     valid_d  = 1'b1;
                     state_d  = StDone;
                  end else begin
                     addend_d = in_div ? abs2 : abs1;
                     acc_d    = {{XLEN{1'b0}}, in_div ? abs1 : abs2};
                     state_d  = StBusy;
                  end
               end
            end
            StBusy: begin
               acc_d = step_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntW'(XLEN-1)) begin
                  result_d = final_res;
                  valid_d  = 1'b1;
                  state_d  = StDone;
               end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         f3_q     <= '0;
         sign_q   <= 1'b0;
         addend_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         rd_q     <= '0;
         rd_en_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         sign_q   <= sign_d;
         addend_q <= addend_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         rd_en_q  <= rd_en_d;
         valid_q  <= valid_d;
      end
   end

   assign result_valid_o = valid_q;
   assign result_o       = result_q;
   assign rd_o           = rd_q;
   assign rd_enable_o    = rd_en_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: reference arithmetic model, latency, stall, flush and reset.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst, op_valid, rd_enable_i, flush_i;
   logic [2:0]  funct3;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  rd_i;
   logic        stall_req_o, result_valid_o, rd_enable_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] res;
      int          lat;
      logic [4:0]  rd;
      logic        en;
   } exp_t;
   exp_t sb[$];

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
   } stim_t;

   always #5 clk = ~clk;

   ex_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .op_valid      (op_valid),
      .funct3        (funct3),
      .reg1_i        (reg1_i),
      .reg2_i        (reg2_i),
      .rd_i          (rd_i),
      .rd_enable_i   (rd_enable_i),
      .flush_i       (flush_i),
      .stall_req_o   (stall_req_o),
      .result_valid_o(result_valid_o),
      .result_o      (result_o),
      .rd_o          (rd_o),
      .rd_enable_o   (rd_enable_o)
   );

   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa, sb6, sub, p;
      logic [63:0]        up;
      logic signed [31:0] as_, bs_, r;
      logic               ovf;
      sa  = {{32{a[31]}}, a};
      sb6 = {{32{b[31]}}, b};
      sub = {32'b0, b};
      as_ = a;
      bs_ = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb6; return p[31:0]; end
         3'd1: begin p = sa * sb6; return p[63:32]; end
         3'd2: begin p = sa * sub; return p[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            r = as_ / bs_;
            return r;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            r = as_ % bs_;
            return r;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
      if (f3[2] && (b == 0)) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Presents one op, holds it while stalled, and reports what the DUT produced.
   task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic en, input bit hold_done,
                           output int lat, output logic [31:0] res, output logic [4:0] rdo,
                           output logic eno, output int scnt, output logic sav,
                           output bit tmo);
      bit got = 0;
      int cyc = 0;
      scnt = 0;
      lat  = -1;
      res  = '0;
      rdo  = '0;
      eno  = 1'b0;
      sav  = 1'b0;
      @(negedge clk);
      op_valid    = 1'b1;
      funct3      = f3;
      reg1_i      = a;
      reg2_i      = b;
      rd_i        = rd;
      rd_enable_i = en;
      #1;
      while (!got && cyc <= 40) begin
         if (result_valid_o) begin
            got = 1;
            lat = cyc;
            res = result_o;
            rdo = rd_o;
            eno = rd_enable_o;
            sav = stall_req_o;
         end else begin
            if (stall_req_o) scnt++;
            @(negedge clk);
            #1;
            cyc++;
         end
      end
      if (hold_done) begin
         @(negedge clk);
      end
      op_valid = 1'b0;
      tmo = !got;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      op_valid = 1'b0;
      flush_i  = 1'b0;
      funct3   = '0;
      reg1_i   = '0;
      reg2_i   = '0;
      rd_i     = '0;
      rd_enable_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({result_valid_o, stall_req_o, rd_enable_o, rd_o, result_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b stall=%b en=%b rd=%0d res=%h, required all 0",
                  result_valid_o, stall_req_o, rd_enable_o, rd_o, result_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_arith(input string name, input stim_t tab[]);
      int lat, scnt;
      logic [31:0] res;
      logic [4:0] rdo;
      logic eno, sav;
      bit tmo;
      exp_t e;
      foreach (tab[i]) begin
         sb.push_back('{ref_res(tab[i].f3, tab[i].a, tab[i].b),
                        ref_lat(tab[i].f3, tab[i].a, tab[i].b), 5'(i + 3), i[0]});
         issue_op(tab[i].f3, tab[i].a, tab[i].b, 5'(i + 3), i[0], 1'b0,
                  lat, res, rdo, eno, scnt, sav, tmo);
         e = sb.pop_front();
         n_checks++;
         if (tmo) begin
            n_fail++;
            $display("FAIL %s[%0d] timeout: no result_valid_o within 40 cycles", name, i);
         end else begin
            if (res !== e.res) begin
               n_fail++;
               $display("FAIL %s[%0d] result: got %h required %h", name, i, res, e.res);
            end
            n_checks++;
            if (lat != e.lat) begin
               n_fail++;
               $display("FAIL %s[%0d] latency: got %0d required %0d", name, i, lat, e.lat);
            end
            n_checks++;
            if (rdo !== e.rd || eno !== e.en) begin
               n_fail++;
               $display("FAIL %s[%0d] rd: got %0d/%b required %0d/%b", name, i, rdo, eno,
                        e.rd, e.en);
            end
            n_checks++;
            if (scnt != e.lat || sav !== 1'b0) begin
               n_fail++;
               $display("FAIL %s[%0d] stall: got %0d cycles (at valid %b) required %0d (0)",
                        name, i, scnt, sav, e.lat);
            end
         end
      end
   endtask

   task automatic test_hold_done();
      int lat, scnt, pulses = 0, stalls = 0;
      logic [31:0] res;
      logic [4:0] rdo;
      logic eno, sav;
      bit tmo;
      issue_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 1'b1, lat, res, rdo, eno, scnt, sav, tmo);
      n_checks++;
      if (tmo || res !== 32'hFFFF_FFEB || rdo !== 5'd5 || lat != 33) begin
         n_fail++;
         $display("FAIL hold_result: got %h rd=%0d lat=%0d required ffffffeb rd=5 lat=33",
                  res, rdo, lat);
      end
      repeat (40) begin
         @(negedge clk);
         #1;
         if (result_valid_o) pulses++;
         if (stall_req_o) stalls++;
      end
      n_checks++;
      if (pulses != 0 || stalls != 0) begin
         n_fail++;
         $display("FAIL hold_single_pulse: extra pulses %0d stalls %0d required 0 0",
                  pulses, stalls);
      end
   endtask

   task automatic test_flush();
      int pulses = 0;
      @(negedge clk);
      op_valid = 1'b1;
      funct3   = 3'd5;
      reg1_i   = 32'd100;
      reg2_i   = 32'd7;
      rd_i     = 5'd12;
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (stall_req_o !== 1'b0 || result_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle: stall=%b valid=%b required 0 0", stall_req_o, result_valid_o);
      end
      // op_valid and flush_i both high in IDLE: flush wins, no stall, no accept.
      n_checks++;
      if (stall_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_priority: stall=%b required 0", stall_req_o);
      end
      @(negedge clk);
      flush_i  = 1'b0;
      op_valid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (result_valid_o || stall_req_o) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL flush_no_result: %0d active cycles required 0", pulses);
      end
   endtask

   task automatic test_reset_busy();
      int lat, scnt;
      logic [31:0] res;
      logic [4:0] rdo;
      logic eno, sav;
      bit tmo;
      @(negedge clk);
      op_valid    = 1'b1;
      funct3      = 3'd0;
      reg1_i      = 32'd1000;
      reg2_i      = 32'd3;
      rd_i        = 5'd20;
      rd_enable_i = 1'b1;
      repeat (20) @(negedge clk);
      rst      = 1'b1;
      op_valid = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if ({result_valid_o, stall_req_o, rd_enable_o, rd_o, result_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_busy: valid=%b stall=%b en=%b rd=%0d res=%h, required all 0",
                  result_valid_o, stall_req_o, rd_enable_o, rd_o, result_o);
      end
      rst = 1'b0;
      issue_op(3'd0, 32'h0001_0003, 32'h0000_0101, 5'd9, 1'b1, 1'b0,
               lat, res, rdo, eno, scnt, sav, tmo);
      n_checks++;
      if (tmo || res !== 32'h0101_0303 || rdo !== 5'd9 || lat != 33) begin
         n_fail++;
         $display("FAIL reset_recover: got %h rd=%0d lat=%0d required 01010303 rd=9 lat=33",
                  res, rdo, lat);
      end
   endtask

   initial begin
      stim_t mul_tab[], div_tab[], b2b_tab[];
      mul_tab = '{
         '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD},
         '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{3'd1, 32'h8000_0000, 32'h8000_0000},
         '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF},
         '{3'd0, 32'h1234_5678, 32'h9ABC_DEF0}
      };
      div_tab = '{
         '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002},
         '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002},
         '{3'd5, 32'd100, 32'd7},
         '{3'd7, 32'd100, 32'd7},
         '{3'd5, 32'h0000_1234, 32'h0},
         '{3'd6, 32'h0000_1234, 32'h0},
         '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF},
         '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF},
         '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF},
         '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE}
      };
      b2b_tab = new[6];
      foreach (b2b_tab[i]) begin
         b2b_tab[i].f3 = 3'($urandom_range(0, 7));
         b2b_tab[i].a  = $urandom;
         b2b_tab[i].b  = (i == 2) ? 32'h0 : $urandom;
      end
      test_reset();
      test_arith("mul", mul_tab);
      test_arith("div", div_tab);
      test_arith("back_to_back", b2b_tab);
      test_hold_done();
      test_flush();
      test_reset_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
